tpm_tis_responder: RTL and testbench
====================================

Name: tpm_tis_responder

Overview:
- TPM-side responder for the byte-wide register-access bus that the host state machine drives.
- Decodes ACCESS (0x0000), STS (0x0018) and DATA_FIFO (0x0024) accesses and runs the TIS command lifecycle READY → RECEPTION → EXECUTION → COMPLETION.
- Buffers command bytes for a downstream command engine and returns that engine's response bytes to the host.
- Used as the bus model in host-side simulation and as the TPM emulation target on hardware.

Parameters:
- CMD_DEPTH, 1024, command buffer capacity in bytes (power of 2).
- RSP_DEPTH, 1024, response buffer capacity in bytes (power of 2).
- ACCESS_LATENCY, 4, cycles from accepted tpmStart to tpmGotResponse (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tpmAddr  in  16  register address, sampled with tpmStart.
- tpmInData  in  8  write data, sampled with tpmStart.
- tpmIsWrite  in  1  1 = write, 0 = read, sampled with tpmStart.
- tpmStart  in  1  one-cycle access request.
- tpmIsReady  out  1  responder idle and able to accept tpmStart.
- tpmGotResponse  out  1  one-cycle pulse, read data valid.
- tpmOutData  out  8  read data, held until the next read completes.
- cmdDout  out  8  head of the command buffer (first-word fall-through).
- cmdEmpty  out  1  command buffer empty.
- cmdRden  in  1  pop the command buffer head.
- cmdGo  out  1  one-cycle pulse on entry to EXECUTION.
- rspDin  in  8  response byte.
- rspWren  in  1  push a response byte.
- rspDone  in  1  response complete.
- cmdOverflow  out  1  sticky: a command byte was dropped.

Behaviour:
- Reset values: tpmIsReady=1, tpmGotResponse=0, tpmOutData=0, cmdGo=0, cmdOverflow=0, cmdEmpty=1. State=READY, locality inactive, both buffers cleared. Reset mid-access aborts the access with no tpmGotResponse pulse.
- Bus handshake:
  - tpmStart is accepted only while tpmIsReady=1; a start while busy is ignored.
  - On acceptance, latch address, data and write flag; tpmIsReady=0 from the next cycle.
  - Register side effects occur on the acceptance cycle +1.
  - Reads: tpmGotResponse pulses exactly ACCESS_LATENCY cycles after acceptance, with tpmOutData valid, while tpmIsReady is still 0. tpmIsReady returns to 1 the next cycle.
  - Writes: no tpmGotResponse pulse; tpmIsReady returns to 1 ACCESS_LATENCY+1 cycles after acceptance.
  - Read data is captured at the access's side-effect point, not at the pulse.
- ACCESS (0x0000):
  - Read returns 0xA0 when locality is active, 0x80 otherwise.
  - Write with bit1 set (requestUse) → active. Write with bit5 set (activeLocality) → inactive. Both bits set → inactive.
- STS (0x0018) read byte:
  - bit7 stsValid = 1; bit6 commandReady = (READY); bit4 dataAvail = (COMPLETION and response bytes remain); bit3 expect = (RECEPTION); bit2 selfTestDone = 1; all other bits 0.
  - Resulting values: READY=0xC4, RECEPTION=0x8C, EXECUTION=0x84, COMPLETION with data=0x94, COMPLETION drained=0x84.
- STS writes:
  - 0x40 (commandReady) from any state → READY; clear both buffers and cmdOverflow.
  - 0x20 (tpmGo) in RECEPTION → EXECUTION and pulse cmdGo one cycle. Ignored in any other state.
  - Any other value is ignored.
- DATA_FIFO (0x0024):
  - Write in READY or RECEPTION pushes the byte and forces RECEPTION.
  - A push when CMD_DEPTH bytes are held drops the byte and sets cmdOverflow.
  - Writes in EXECUTION or COMPLETION are ignored.
  - Read in COMPLETION with bytes remaining returns the head byte and pops it.
  - Otherwise a read returns 0xFF with no pop.
- Any other address: read returns 0xFF; write is ignored.
- Locality is not enforced; every access is serviced.
- Command engine side:
  - cmdRden while cmdEmpty=1 is ignored.
  - rspWren is honoured only in EXECUTION; pushes beyond RSP_DEPTH are dropped.
  - rspDone in EXECUTION → COMPLETION next cycle; outside EXECUTION it is ignored.
  - rspWren and rspDone in the same cycle: the byte is stored, then the state moves to COMPLETION.
  - A STS 0x40 side effect in the same cycle as rspDone wins (state → READY).
  - Pointer and count arithmetic wraps modulo buffer depth; counts are $clog2(depth)+1 bits.

Test Plan:
- Reset, then read STS → tpmGotResponse 4 cycles after start, tpmOutData=0xC4, tpmIsReady high the following cycle.
- Write 0x02 to 0x0000 then read 0x0000 → 0xA0. Write 0x20 to 0x0000 then read 0x0000 → 0x80.
- Write 10 bytes 0x80,0x01,0,0,0,0x0C,0,0,0x01,0x44 to 0x24 → STS=0x8C. Write 0x20 to STS → cmdGo pulse, STS=0x84. Engine pops 10 bytes in order, then cmdEmpty=1.
- Engine pushes a 10-byte response (bytes 2..5 = 00 00 00 0A) then rspDone → STS=0x94. Ten reads of 0x24 return the bytes in order, then STS=0x84 and an 11th read returns 0xFF.
- Write 1025 bytes to 0x24 → cmdOverflow=1, 1024 bytes held. STS write 0x40 → STS=0xC4, cmdEmpty=1, cmdOverflow=0.
- tpmStart pulsed while tpmIsReady=0 → ignored, no extra response pulse. tpmGo written in READY → no cmdGo, STS stays 0xC4. Reset asserted mid-read → no tpmGotResponse, all outputs at reset values.

Source files
------------

// File: rtl/tpm_tis_responder.sv
// TPM-side TIS register responder: decodes ACCESS/STS/DATA_FIFO accesses from the
// byte-wide host bus, runs the command lifecycle, and buffers command/response bytes.
module tpm_tis_responder #(
  parameter int CMD_DEPTH      = 1024,
  parameter int RSP_DEPTH      = 1024,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] tpmAddr,
  input  logic [7:0]  tpmInData,
  input  logic        tpmIsWrite,
  input  logic        tpmStart,
  output logic        tpmIsReady,
  output logic        tpmGotResponse,
  output logic [7:0]  tpmOutData,
  output logic [7:0]  cmdDout,
  output logic        cmdEmpty,
  input  logic        cmdRden,
  output logic        cmdGo,
  input  logic [7:0]  rspDin,
  input  logic        rspWren,
  input  logic        rspDone,
  output logic        cmdOverflow
);

  localparam int CAW  = $clog2(CMD_DEPTH);
  localparam int RAW  = $clog2(RSP_DEPTH);
  localparam int CNTW = $clog2(ACCESS_LATENCY + 2);

  localparam logic [15:0]     ADDR_ACCESS = 16'h0000;
  localparam logic [15:0]     ADDR_STS    = 16'h0018;
  localparam logic [15:0]     ADDR_FIFO   = 16'h0024;
  localparam logic [CAW:0]    CMD_FULL    = (CAW + 1)'(CMD_DEPTH);
  localparam logic [RAW:0]    RSP_FULL    = (RAW + 1)'(RSP_DEPTH);
  localparam logic [CAW:0]    CMD_NONE    = {(CAW + 1){1'b0}};
  localparam logic [RAW:0]    RSP_NONE    = {(RAW + 1){1'b0}};
  localparam logic [CNTW-1:0] LAT_PULSE   = CNTW'(ACCESS_LATENCY - 1);
  localparam logic [CNTW-1:0] LAT_DONE    = CNTW'(ACCESS_LATENCY);

  typedef enum logic [1:0] {
    S_READY     = 2'd0,
    S_RECEPTION = 2'd1,
    S_EXECUTION = 2'd2,
    S_COMPLETION = 2'd3
  } tisState_t;

  function automatic logic [7:0] stsByte(input tisState_t s, input logic dataLeft);
    stsByte = {1'b1, (s == S_READY), 1'b0, ((s == S_COMPLETION) && dataLeft),
               (s == S_RECEPTION), 1'b1, 2'b00};
  endfunction

  tisState_t       state, nextState;
  logic            localityActive, localityNext;
  logic            busy, latWrite;
  logic [CNTW-1:0] cnt;
  logic [7:0]      rdCap, rdNow;
  logic            accept, clearAll, goPulse, cmdPush, cmdDrop, cmdPop, rspPush, rspPop;

  logic [7:0]   cmdMem [CMD_DEPTH];
  logic [CAW-1:0] cmdWrPtr, cmdRdPtr;
  logic [CAW:0]   cmdCount;
  logic [7:0]   rspMem [RSP_DEPTH];
  logic [RAW-1:0] rspWrPtr, rspRdPtr;
  logic [RAW:0]   rspCount;

  assign accept   = tpmStart && tpmIsReady;
  assign cmdDout  = cmdMem[cmdRdPtr];
  assign cmdEmpty = (cmdCount == CMD_NONE);
  assign cmdPop   = cmdRden && !cmdEmpty && !clearAll;
  assign rspPush  = rspWren && (state == S_EXECUTION) && (rspCount != RSP_FULL);

  // Access decode: register side effects, read data and next lifecycle state
  always_comb begin
    nextState    = state;
    localityNext = localityActive;
    clearAll     = 1'b0;
    goPulse      = 1'b0;
    cmdPush      = 1'b0;
    cmdDrop      = 1'b0;
    rspPop       = 1'b0;
    rdNow        = 8'hFF;
    if (accept && tpmIsWrite) begin
      case (tpmAddr)
        ADDR_ACCESS: begin
          if (tpmInData[5])      localityNext = 1'b0;
          else if (tpmInData[1]) localityNext = 1'b1;
          else                   localityNext = localityActive;
        end
        ADDR_STS: begin
          if (tpmInData == 8'h40) begin
            clearAll  = 1'b1;
            nextState = S_READY;
          end else if ((tpmInData == 8'h20) && (state == S_RECEPTION)) begin
            goPulse   = 1'b1;
            nextState = S_EXECUTION;
          end else begin
            nextState = state;
          end
        end
        ADDR_FIFO: begin
          if ((state == S_READY) || (state == S_RECEPTION)) begin
            nextState = S_RECEPTION;
            if (cmdCount == CMD_FULL) cmdDrop = 1'b1;
            else                      cmdPush = 1'b1;
          end else begin
            nextState = state;
          end
        end
        default: nextState = state;
      endcase
    end else if (accept) begin
      case (tpmAddr)
        ADDR_ACCESS: rdNow = localityActive ? 8'hA0 : 8'h80;
        ADDR_STS:    rdNow = stsByte(state, rspCount != RSP_NONE);
        ADDR_FIFO: begin
          if ((state == S_COMPLETION) && (rspCount != RSP_NONE)) begin
            rdNow  = rspMem[rspRdPtr];
            rspPop = 1'b1;
          end else begin
            rdNow  = 8'hFF;
          end
        end
        default: rdNow = 8'hFF;
      endcase
    end else begin
      rdNow = 8'hFF;
    end
    // A commandReady write outranks a simultaneous rspDone
    if (rspDone && (state == S_EXECUTION) && !clearAll) nextState = S_COMPLETION;
    else                                                nextState = nextState;
  end

  // Lifecycle state, locality and bus handshake timing
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_READY;
      localityActive <= 1'b0;
      busy           <= 1'b0;
      cnt            <= {CNTW{1'b0}};
      latWrite       <= 1'b0;
      rdCap          <= 8'h00;
      tpmIsReady     <= 1'b1;
      tpmGotResponse <= 1'b0;
      tpmOutData     <= 8'h00;
      cmdGo          <= 1'b0;
    end else begin
      state          <= nextState;
      localityActive <= localityNext;
      cmdGo          <= goPulse;
      tpmGotResponse <= 1'b0;
      if (accept) begin
        busy       <= 1'b1;
        cnt        <= {{(CNTW - 1){1'b0}}, 1'b1};
        latWrite   <= tpmIsWrite;
        rdCap      <= rdNow;
        tpmIsReady <= 1'b0;
        if (!tpmIsWrite && (ACCESS_LATENCY == 1)) begin
          tpmGotResponse <= 1'b1;
          tpmOutData     <= rdNow;
        end
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (!latWrite && (cnt == LAT_PULSE)) begin
          tpmGotResponse <= 1'b1;
          tpmOutData     <= rdCap;
        end
        if (cnt == LAT_DONE) begin
          busy       <= 1'b0;
          tpmIsReady <= 1'b1;
        end
      end
    end
  end

  // Buffer pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset || clearAll) begin
      cmdWrPtr    <= {CAW{1'b0}};
      cmdRdPtr    <= {CAW{1'b0}};
      cmdCount    <= CMD_NONE;
      rspWrPtr    <= {RAW{1'b0}};
      rspRdPtr    <= {RAW{1'b0}};
      rspCount    <= RSP_NONE;
      cmdOverflow <= 1'b0;
    end else begin
      if (cmdDrop) cmdOverflow <= 1'b1;
      if (cmdPush) cmdWrPtr <= cmdWrPtr + 1'b1;
      if (cmdPop)  cmdRdPtr <= cmdRdPtr + 1'b1;
      case ({cmdPush, cmdPop})
        2'b10:   cmdCount <= cmdCount + 1'b1;
        2'b01:   cmdCount <= cmdCount - 1'b1;
        default: cmdCount <= cmdCount;
      endcase
      if (rspPush) rspWrPtr <= rspWrPtr + 1'b1;
      if (rspPop)  rspRdPtr <= rspRdPtr + 1'b1;
      case ({rspPush, rspPop})
        2'b10:   rspCount <= rspCount + 1'b1;
        2'b01:   rspCount <= rspCount - 1'b1;
        default: rspCount <= rspCount;
      endcase
    end
  end

  // Buffer storage, left unreset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (cmdPush) cmdMem[cmdWrPtr] <= tpmInData;
    if (rspPush) rspMem[rspWrPtr] <= rspDin;
  end

endmodule

// File: tb/tb_tpm_tis_responder.sv
// Directed self-checking bench for tpm_tis_responder with hand-computed expectations.
module tb_tpm_tis_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tpmAddr;
  logic [7:0]  tpmInData;
  logic        tpmIsWrite, tpmStart;
  logic        tpmIsReady, tpmGotResponse;
  logic [7:0]  tpmOutData, cmdDout;
  logic        cmdEmpty, cmdRden, cmdGo;
  logic [7:0]  rspDin;
  logic        rspWren, rspDone, cmdOverflow;

  int checks = 0;
  int errors = 0;
  int goSeen, gotSeen, readyAt, gotAt, popped;
  logic [7:0] rd, lastPop;
  logic [7:0] cmdBytes [10];
  logic [7:0] rspBytes [10];

  tpm_tis_responder dut (
    .clk(clk), .reset(reset), .tpmAddr(tpmAddr), .tpmInData(tpmInData),
    .tpmIsWrite(tpmIsWrite), .tpmStart(tpmStart), .tpmIsReady(tpmIsReady),
    .tpmGotResponse(tpmGotResponse), .tpmOutData(tpmOutData), .cmdDout(cmdDout),
    .cmdEmpty(cmdEmpty), .cmdRden(cmdRden), .cmdGo(cmdGo), .rspDin(rspDin),
    .rspWren(rspWren), .rspDone(rspDone), .cmdOverflow(cmdOverflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    tpmAddr = a; tpmInData = d; tpmIsWrite = 1'b1; tpmStart = 1'b1;
    @(posedge clk); #1;
    tpmStart = 1'b0;
    goSeen = 0; gotSeen = 0; readyAt = 0;
    for (int j = 1; j <= 12 && readyAt == 0; j++) begin
      if (cmdGo) goSeen++;
      if (tpmGotResponse) gotSeen++;
      if (tpmIsReady) readyAt = j;
      else begin @(posedge clk); #1; end
    end
    check("wr_ready_latency", readyAt, 5);
    check("wr_no_response", gotSeen, 0);
  endtask

  task automatic busRead(input logic [15:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    tpmAddr = a; tpmInData = 8'h00; tpmIsWrite = 1'b0; tpmStart = 1'b1;
    @(posedge clk); #1;
    tpmStart = 1'b0;
    gotAt = 0; d = 8'hxx;
    for (int j = 1; j <= 12 && gotAt == 0; j++) begin
      if (tpmGotResponse) begin
        gotAt = j;
        d = tpmOutData;
        check("rd_busy_at_pulse", tpmIsReady, 0);
      end else begin
        @(posedge clk); #1;
      end
    end
    check("rd_latency", gotAt, 4);
    @(posedge clk); #1;
    check("rd_ready_after", tpmIsReady, 1);
  endtask

  initial begin
    cmdBytes = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44};
    rspBytes = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    reset = 1'b1; tpmAddr = 16'h0000; tpmInData = 8'h00; tpmIsWrite = 1'b0;
    tpmStart = 1'b0; cmdRden = 1'b0; rspDin = 8'h00; rspWren = 1'b0; rspDone = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_ready", tpmIsReady, 1);
    check("rst_got", tpmGotResponse, 0);
    check("rst_outdata", tpmOutData, 8'h00);
    check("rst_cmdgo", cmdGo, 0);
    check("rst_overflow", cmdOverflow, 0);
    check("rst_empty", cmdEmpty, 1);
    busRead(16'h0018, rd); check("sts_reset", rd, 8'hC4);

    // Locality
    busWrite(16'h0000, 8'h02); busRead(16'h0000, rd); check("acc_active", rd, 8'hA0);
    busWrite(16'h0000, 8'h20); busRead(16'h0000, rd); check("acc_inactive", rd, 8'h80);
    busWrite(16'h0000, 8'h02); busWrite(16'h0000, 8'h22);
    busRead(16'h0000, rd); check("acc_both_bits", rd, 8'h80);
    busRead(16'h0100, rd); check("unmapped_read", rd, 8'hFF);

    // Command reception and go
    for (int i = 0; i < 10; i++) busWrite(16'h0024, cmdBytes[i]);
    busRead(16'h0018, rd); check("sts_reception", rd, 8'h8C);
    check("cmd_not_empty", cmdEmpty, 0);
    busRead(16'h0024, rd); check("fifo_read_reception", rd, 8'hFF);
    busWrite(16'h0018, 8'h20); check("go_pulse", goSeen, 1);
    busRead(16'h0018, rd); check("sts_execution", rd, 8'h84);
    busWrite(16'h0024, 8'h55);
    for (int i = 0; i < 10; i++) begin
      check("cmd_byte", cmdDout, cmdBytes[i]);
      cmdRden = 1'b1; @(posedge clk); #1; cmdRden = 1'b0;
    end
    check("cmd_drained", cmdEmpty, 1);

    // Response path, last byte together with rspDone
    for (int i = 0; i < 10; i++) begin
      rspDin = rspBytes[i]; rspWren = 1'b1; rspDone = (i == 9);
      @(posedge clk); #1;
    end
    rspWren = 1'b0; rspDone = 1'b0;
    busRead(16'h0018, rd); check("sts_completion", rd, 8'h94);
    for (int i = 0; i < 10; i++) begin
      busRead(16'h0024, rd); check("rsp_byte", rd, rspBytes[i]);
    end
    busRead(16'h0018, rd); check("sts_drained", rd, 8'h84);
    busRead(16'h0024, rd); check("fifo_read_empty", rd, 8'hFF);

    // Overflow at CMD_DEPTH
    busWrite(16'h0018, 8'h40);
    busRead(16'h0018, rd); check("sts_ready_again", rd, 8'hC4);
    for (int i = 0; i < 1024; i++) busWrite(16'h0024, 8'(i));
    check("no_overflow_at_full", cmdOverflow, 0);
    busWrite(16'h0024, 8'hEE);
    check("overflow_set", cmdOverflow, 1);
    check("head_kept", cmdDout, 8'h00);
    busWrite(16'h0018, 8'h20); check("go_pulse_full", goSeen, 1);
    popped = 0; lastPop = 8'h00;
    for (int i = 0; i < 1100 && !cmdEmpty; i++) begin
      lastPop = cmdDout; cmdRden = 1'b1; @(posedge clk); #1; cmdRden = 1'b0; popped++;
    end
    check("held_count", popped, 1024);
    check("held_last", lastPop, 8'hFF);
    busWrite(16'h0024, 8'h11);
    busWrite(16'h0024, 8'h12);
    busWrite(16'h0018, 8'h40);
    busRead(16'h0018, rd); check("sts_after_clear", rd, 8'hC4);
    check("empty_after_clear", cmdEmpty, 1);
    check("overflow_cleared", cmdOverflow, 0);

    // Start while busy is ignored
    @(posedge clk); #1;
    tpmAddr = 16'h0018; tpmIsWrite = 1'b0; tpmStart = 1'b1;
    @(posedge clk); #1;
    tpmStart = 1'b0;
    @(posedge clk); #1;
    tpmAddr = 16'h0000; tpmInData = 8'h02; tpmIsWrite = 1'b1; tpmStart = 1'b1;
    @(posedge clk); #1;
    tpmStart = 1'b0;
    gotSeen = 0;
    for (int j = 0; j < 12; j++) begin
      if (tpmGotResponse) gotSeen++;
      @(posedge clk); #1;
    end
    check("busy_start_pulses", gotSeen, 1);
    busRead(16'h0000, rd); check("busy_start_ignored", rd, 8'h80);

    // tpmGo in READY is ignored
    busWrite(16'h0018, 8'h20); check("go_in_ready", goSeen, 0);
    busRead(16'h0018, rd); check("sts_go_ready", rd, 8'hC4);

    // Reset in the middle of a read
    busWrite(16'h0000, 8'h02);
    busWrite(16'h0024, 8'h33);
    @(posedge clk); #1;
    tpmAddr = 16'h0018; tpmIsWrite = 1'b0; tpmStart = 1'b1;
    @(posedge clk); #1;
    tpmStart = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    gotSeen = 0;
    for (int j = 0; j < 8; j++) begin
      if (tpmGotResponse) gotSeen++;
      @(posedge clk); #1;
    end
    check("midreset_no_pulse", gotSeen, 0);
    check("midreset_ready", tpmIsReady, 1);
    check("midreset_outdata", tpmOutData, 8'h00);
    check("midreset_empty", cmdEmpty, 1);
    check("midreset_overflow", cmdOverflow, 0);
    check("midreset_cmdgo", cmdGo, 0);
    busRead(16'h0018, rd); check("midreset_sts", rd, 8'hC4);
    busRead(16'h0000, rd); check("midreset_locality", rd, 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
